// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits (LSB first), optional parity, one stop bit.
// Latency: 2-cycle input synchronizer; result pulses one cycle after the last STOP-state cycle.
// Backpressure: none; DATA_VALID/PAR_ERR/STP_ERR are single-cycle pulses that must be taken when seen.
//
// Ports:
//   CLK        receiver clock, PRESCALE x baud
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, asynchronous to CLK
//   PRESCALE   oversampling ratio (8, 16 or 32), captured at start detection
//   PAR_EN     frame carries a parity bit, captured at start detection
//   PAR_TYP    0 = even, 1 = odd parity, captured at start detection
//   P_DATA     last good received word
//   DATA_VALID one-cycle pulse when P_DATA is updated
//   PAR_ERR    one-cycle pulse on parity mismatch
//   STP_ERR    one-cycle pulse when the stop bit is sampled low
//   RX_BUSY    high while a frame is in progress
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  RX_BUSY
);

  localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BC_W-1:0]       LAST_BIT = BC_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO      = PRESCALE_W'(2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;

  logic                  rx_s1, rx_s2, line;
  logic [1:0]            prime_q;
  logic                  armed_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  par_en_q, par_typ_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic                  smp_a, smp_b, bit_smp;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bad_q, stop_bad_q;

  logic [PRESCALE_W-1:0] half;
  logic                  last_edge, at_a, at_b, at_v, at_g;
  logic                  vote, start_det, frame_end;

  assign line      = rx_s2;
  assign half      = p_q >> 1;
  assign last_edge = (edge_cnt == p_q - ONE);
  assign at_a      = (edge_cnt == half - ONE);
  assign at_b      = (edge_cnt == half);
  assign at_v      = (edge_cnt == half + ONE);
  assign at_g      = (edge_cnt == half + TWO);
  // Third vote input is the live line at P/2+1; the other two were captured earlier.
  assign vote      = (smp_a & smp_b) | (smp_a & line) | (smp_b & line);
  assign start_det = (state_q == IDLE) && armed_q && !line;
  assign frame_end = (state_q == STOP) && last_edge;
  assign RX_BUSY   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_det) state_d = START;
      START: begin
        // bit_smp was registered one cycle earlier, at P/2+1
        if (at_g && bit_smp)  state_d = IDLE;
        else if (last_edge)   state_d = DATA;
      end
      DATA:    if (last_edge && bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_d = STOP;
      STOP:    if (last_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Synchronizer and re-arm logic. The synchronizer resets to idle-high, so prime_q
  // blocks arming until it has been refilled with real line values; a line held low
  // out of reset, or a break, never looks like a fresh start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      rx_s1   <= RX_IN;
      rx_s2   <= rx_s1;
      prime_q <= {prime_q[0], 1'b1};
      if (start_det)
        armed_q <= 1'b0;
      else if (prime_q[1] && line && (state_q == IDLE || state_q == STOP))
        armed_q <= 1'b1;
    end
  end

  // Configuration capture and bit/edge counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_q       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      if (start_det) begin
        p_q       <= PRESCALE;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
      // The detect cycle is edge 0 of the start bit, so START begins at edge 1.
      if (start_det)
        edge_cnt <= ONE;
      else if (state_q == IDLE || state_d == IDLE || last_edge)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + ONE;

      if (state_q != DATA)
        bit_cnt <= '0;
      else if (last_edge)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Mid-bit sampling, shift register and per-frame error flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_a      <= 1'b0;
      smp_b      <= 1'b0;
      bit_smp    <= 1'b0;
      data_q     <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        if (at_a) smp_a   <= line;
        if (at_b) smp_b   <= line;
        if (at_v) bit_smp <= vote;
      end
      if (state_q == DATA && at_v)
        data_q <= {vote, data_q[DATA_WIDTH-1:1]};
      if (start_det)
        par_bad_q <= 1'b0;
      else if (state_q == PARITY && at_v)
        par_bad_q <= vote ^ (^data_q) ^ par_typ_q;
      if (state_q == STOP && at_v)
        stop_bad_q <= ~vote;
    end
  end

  // Result pulses land in the first IDLE cycle after STOP
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= frame_end && !par_bad_q && !stop_bad_q;
      PAR_ERR    <= frame_end && par_bad_q;
      STP_ERR    <= frame_end && stop_bad_q;
      if (frame_end && !par_bad_q && !stop_bad_q)
        P_DATA <= data_q;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, RX_BUSY;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .RX_BUSY(RX_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Output monitor: counts high cycles of each pulse, so a stuck pulse shows as a count > 1
  int         dv_cnt, pe_cnt, se_cnt, busy_cnt;
  logic [7:0] first_dat, last_dat;

  always @(negedge CLK) begin
    if (DATA_VALID) begin
      if (dv_cnt == 0) first_dat = P_DATA;
      last_dat = P_DATA;
      dv_cnt++;
    end
    if (PAR_ERR) pe_cnt++;
    if (STP_ERR) se_cnt++;
    if (RX_BUSY) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0; busy_cnt = 0;
    first_dat = 8'h00; last_dat = 8'h00;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Frame index i: 0 = start, 1..8 = data bits 0..7, then parity (if any), then stop.
  // flip_idx inverts the line for one cycle at the middle of that bit; abort_idx asserts
  // reset at the middle of that bit and leaves the task. -1 disables either.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pbit,
                            input bit stp, input int flip_idx, input int abort_idx);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin bits[9] = pbit; bits[10] = stp; nb = 11; end
    else    begin bits[9] = stp;  nb = 10; end
    PRESCALE = p[5:0];
    PAR_EN   = pe;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (i == abort_idx && c == p / 2) begin
          RST = 1'b0;
          return;
        end
        RX_IN = (i == flip_idx && c == p / 2) ? ~bits[i] : bits[i];
      end
    end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge CLK);
    #1;
    check("rst_pdata", P_DATA, 0);
    check("rst_dv",    DATA_VALID, 0);
    check("rst_pe",    PAR_ERR, 0);
    check("rst_se",    STP_ERR, 0);
    check("rst_busy",  RX_BUSY, 0);
    @(negedge CLK);
    RST = 1'b1;
    idle(10);

    // P=8, even parity, 0xA5 (four ones -> parity bit 0). Busy spans START (7 cycles,
    // the detect cycle being edge 0) + 8 data + parity + stop bits = 11*8-1 cycles.
    PAR_TYP = 1'b0;
    clear_mon();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, -1);
    idle(20);
    check("a5_dv",    dv_cnt, 1);
    check("a5_pdata", P_DATA, 8'hA5);
    check("a5_pe",    pe_cnt, 0);
    check("a5_se",    se_cnt, 0);
    check("a5_busy",  busy_cnt, 87);

    // P=16, no parity, back-to-back frames
    clear_mon();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(40);
    check("b2b_dv",    dv_cnt, 2);
    check("b2b_first", first_dat, 8'h3C);
    check("b2b_last",  last_dat, 8'hC3);

    // P=32, odd parity: 0xA5 needs parity 1, send 0
    PAR_TYP = 1'b1;
    clear_mon();
    send_frame(8'hA5, 32, 1'b1, 1'b0, 1'b1, -1, -1);
    idle(80);
    check("par_pe",    pe_cnt, 1);
    check("par_dv",    dv_cnt, 0);
    check("par_se",    se_cnt, 0);
    check("par_pdata", P_DATA, 8'hC3);
    PAR_TYP = 1'b0;

    // P=8, no parity, stop bit low, then a good frame
    clear_mon();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(20);
    check("stp_se",    se_cnt, 1);
    check("stp_pe",    pe_cnt, 0);
    check("stp_dv",    dv_cnt, 0);
    clear_mon();
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(20);
    check("rec_dv",    dv_cnt, 1);
    check("rec_pdata", P_DATA, 8'h0F);

    // Glitch: two low cycles at P=8; START runs edges 1..6 before abandoning
    clear_mon();
    PRESCALE = 6'd8;
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK); RX_IN = 1'b1;
    idle(30);
    check("gl_dv",    dv_cnt, 0);
    check("gl_pe",    pe_cnt, 0);
    check("gl_se",    se_cnt, 0);
    check("gl_busy",  RX_BUSY, 0);
    check("gl_bcnt",  busy_cnt, 6);

    // One-cycle flip in the middle of data bit 3 (frame index 4); vote must recover it
    clear_mon();
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, 4, -1);
    idle(40);
    check("nz_dv",    dv_cnt, 1);
    check("nz_pdata", P_DATA, 8'h5A);

    // Break: line low for 15 bit times -> one STP_ERR, no re-arm until line returns high
    clear_mon();
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (120) @(negedge CLK);
    check("brk_se",   se_cnt, 1);
    check("brk_dv",   dv_cnt, 0);
    check("brk_busy", RX_BUSY, 0);
    idle(20);
    clear_mon();
    send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(20);
    check("brk_rec_dv",    dv_cnt, 1);
    check("brk_rec_pdata", P_DATA, 8'h42);

    // Reset in the middle of data bit 4 (frame index 5)
    clear_mon();
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1, 5);
    #1;
    check("mrst_pdata", P_DATA, 0);
    check("mrst_busy",  RX_BUSY, 0);
    check("mrst_dv",    DATA_VALID, 0);
    @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    idle(10);
    clear_mon();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(20);
    check("mrst_rec_dv",    dv_cnt, 1);
    check("mrst_rec_pdata", P_DATA, 8'h81);
    check("mrst_rec_err",   pe_cnt + se_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Oversampling UART receiver, the far-end counterpart of the UART_TX serializer. It samples the serial line at PRESCALE x baud and recovers LSB-first frames: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit. It presents each good byte on P_DATA with a one-cycle DATA_VALID pulse. Frames with parity or stop errors are flagged and dropped.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the PRESCALE input

Ports:
CLK  input  1  receiver clock, PRESCALE x baud
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line; idle high; asynchronous to CLK
PRESCALE  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last good received word
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated
PAR_ERR  output  1  one-cycle pulse on parity mismatch
STP_ERR  output  1  one-cycle pulse on stop bit sampled low
RX_BUSY  output  1  high while a frame is in progress

Behaviour:
- One clock, CLK. RST is asynchronous and active-low.
- Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, RX_BUSY=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Line input: RX_IN passes through a 2-flop synchronizer. All references to "line" below mean the synchronized value, so there is 2 cycles of input latency.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in the DATA state.
- Sampling: majority vote of the line at edge_cnt = P/2-1, P/2, P/2+1, where P = PRESCALE. The vote result is registered at edge_cnt = P/2+1.
- Configuration capture: PRESCALE, PAR_EN and PAR_TYP are captured when leaving IDLE. Changes mid-frame have no effect. Non-legal PRESCALE values give undefined behaviour.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_BUSY=0.
  - Line=0 moves to START with edge_cnt=1. The detect cycle counts as edge 0.
- START:
  - If the voted sample is 1 (glitch), return to IDLE at edge_cnt=P/2+2 with no outputs.
  - Otherwise, at edge_cnt=P-1, go to DATA with edge_cnt=0 and bit_cnt=0.
- DATA:
  - Voted sample is shifted in LSB first.
  - At edge_cnt=P-1 and bit_cnt=DATA_WIDTH-1, go to PARITY if PAR_EN, else to STOP.
- PARITY:
  - Expected bit = XOR(data) ^ PAR_TYP.
  - At edge_cnt=P-1, go to STOP. The mismatch is held internally until STOP.
- STOP:
  - stop_bad = (voted sample == 0).
  - At edge_cnt=P-1, go to IDLE, and on the next cycle:
    - no error: P_DATA <= data, DATA_VALID=1.
    - parity error: PAR_ERR=1, P_DATA unchanged, DATA_VALID=0.
    - stop error: STP_ERR=1, P_DATA unchanged, DATA_VALID=0.
    - both errors: PAR_ERR and STP_ERR both pulse.
- Output pulses: all pulses last exactly one cycle. P_DATA holds its value until the next good frame.
- RX_BUSY: high from the cycle after start detection through the last STOP cycle.
- Back-to-back frames: a new start edge seen in the IDLE cycle after STOP is accepted. Bit timing slips by 1/P per frame, which is within tolerance.
- Reset mid-frame: the frame is abandoned, all outputs return to reset values, and no pulse is emitted. After reset release, the receiver waits for the line to go high before re-arming; a line held low from reset is not a start bit.
- Break (line held low): the frame is reported as STP_ERR once. The next start requires the line to return high first.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0; send 0xA5 with parity 0 and stop 1 -> one DATA_VALID pulse, P_DATA=0xA5, no errors, RX_BUSY high for 11 bit times.
- PRESCALE=16, PAR_EN=0; send 0x3C then immediately 0xC3 -> two DATA_VALID pulses, P_DATA=0x3C then 0xC3.
- PRESCALE=32, PAR_EN=1, PAR_TYP=1; send 0xA5 with parity bit 0 (expected 1) -> PAR_ERR pulse, DATA_VALID stays 0, P_DATA keeps its previous value.
- PRESCALE=8, PAR_EN=0; send 0x55 with stop bit 0, then line high -> STP_ERR pulse only; a following 0x0F frame is received correctly.
- Glitch: line low for 2 CLK at PRESCALE=8 -> FSM returns to IDLE, no output pulses.
- Single mid-bit noise: one-cycle flip at edge_cnt=P/2 of data bit 3 -> majority vote recovers the correct byte.
- Reset mid-frame: assert RST during data bit 4 -> all outputs 0 immediately; the next full frame 0x81 is received correctly.
